seg7_capture: RTL and testbench

- Receive-side counterpart of the hex-to-7-segment display drivers used across the board designs.
- Samples a time-multiplexed, active-low 7-segment bus (segment lines plus one-hot digit enables) and qualifies each digit pattern for stability.
- Inverse-decodes each pattern back to a hex nibble and presents one assembled multi-digit frame on a valid/ready output.
- Used as a loopback checker for display drivers and to read external 7-segment modules.

---
 rtl/seg7_capture.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_capture.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: samples a time-multiplexed active-low 7-segment bus,
// qualifies each digit for stability, inverse-decodes it to a hex nibble
// and presents assembled multi-digit frames on a valid/ready output.
//
// Handshake: value/blank are a frame when out_valid=1; they hold steady
// until the cycle out_valid && out_ready, at which the frame is consumed.
//
// Optional feature: define SEG7_LOOSE_DECODE_EN to also accept the
// "7 with f lit" (1011000) and "9 without d" (0011000) glyph variants.
module seg7_capture #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    pattern_err
);

    localparam int         IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        last_idx;
    logic [6:0]              last_seg;
    logic [7:0]              cnt;
    logic                    sample_ok;
    logic                    same;
    logic                    commit;

    logic [3:0]              dec_nib;
    logic                    dec_blank;
    logic                    dec_ok;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [4*NUM_DIGITS-1:0] shadow_val_nx;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   shadow_blank_nx;
    logic [NUM_DIGITS-1:0]   captured;
    logic [NUM_DIGITS-1:0]   captured_nx;
    logic                    frame_full;
    logic                    load_frame;
    logic                    valid_nx;

    // A sample exists only when exactly one digit strobe is active.
    assign sample_ok = $onehot(dig_en);
    assign same      = (idx == last_idx) && (seg_n == last_seg);
    // Commit only on the transition into STABLE_CYCLES; the saturating
    // counter then sits above that value so a held digit never recommits.
    assign commit    = sample_ok && same && (cnt == CNT_PRE);

    // Convert the one-hot strobe into a digit index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_en[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Inverse of the standard hex-to-7-segment table (bit6..bit0 = g..a).
    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_ok    = 1'b1;
        case (seg_n)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
`ifdef SEG7_LOOSE_DECODE_EN
            7'b1011000: dec_nib = 4'h7;
            7'b0011000: dec_nib = 4'h9;
`endif
            default:    dec_ok = 1'b0;
        endcase
    end

    // Shadow frame including this cycle's commit, so a completing commit
    // can be presented on the very next cycle.
    always_comb begin
        shadow_val_nx   = shadow_val;
        shadow_blank_nx = shadow_blank;
        captured_nx     = captured;
        if (commit) begin
            shadow_val_nx[4*int'(idx) +: 4] = dec_nib;
            shadow_blank_nx[idx]            = dec_blank;
            captured_nx[idx]                = 1'b1;
        end
        frame_full = &captured_nx;
    end

    // Next-state and frame-load control for the output handshake.
    always_comb begin
        state_nx   = state;
        load_frame = 1'b0;
        valid_nx   = out_valid;
        case (state)
            COLLECT: begin
                if (frame_full) begin
                    state_nx   = PRESENT;
                    load_frame = 1'b1;
                    valid_nx   = 1'b1;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (frame_full) begin
                        load_frame = 1'b1;
                    end else begin
                        valid_nx = 1'b0;
                        state_nx = COLLECT;
                    end
                end
            end
            default: begin
                state_nx = COLLECT;
                valid_nx = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // Stability counter and last-sample tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 8'd0;
            last_idx <= '0;
            last_seg <= 7'd0;
        end else if (!sample_ok) begin
            cnt <= 8'd0;
        end else if (same) begin
            if (cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
        end else begin
            cnt      <= 8'd1;
            last_idx <= idx;
            last_seg <= seg_n;
        end
    end

    // Shadow frame, captured mask, output frame and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val   <= '0;
            shadow_blank <= '0;
            captured     <= '0;
            value        <= '0;
            blank        <= '0;
            out_valid    <= 1'b0;
            pattern_err  <= 1'b0;
        end else begin
            shadow_val   <= shadow_val_nx;
            shadow_blank <= shadow_blank_nx;
            captured     <= load_frame ? '0 : captured_nx;
            out_valid    <= valid_nx;
            pattern_err  <= commit && !dec_ok;
            if (load_frame) begin
                value <= shadow_val_nx;
                blank <= shadow_blank_nx;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture (NUM_DIGITS=2, STABLE_CYCLES=4): directed cases
// followed by randomized bus traffic, checked against a reference model
// through expected-frame and expected-error queues.
module tb_seg7_capture;

    localparam int ND = 2;
    localparam int SC = 4;
    localparam int FW = 32 + 5 * ND;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg_n = 7'h7F;
    logic [ND-1:0]   dig_en = '0;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   blank;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            pattern_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [FW-1:0] exp_q[$];
    int            err_q[$];

    // reference model state
    int         m_prev_idx;
    logic [6:0] m_prev_seg;
    int         m_run;
    int         m_nib[ND];
    bit         m_blk[ND];
    bit         m_cap[ND];
    bit         m_valid;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .dig_en(dig_en),
        .value(value), .blank(blank), .out_valid(out_valid),
        .out_ready(out_ready), .pattern_err(pattern_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] hex_pat(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // decode by searching the forward display table
    task automatic ref_decode(input logic [6:0] p, output int nib, output bit blk, output bit ok);
        nib = 0; blk = 1'b0; ok = 1'b0;
        if (p == 7'h7F) begin blk = 1'b1; ok = 1'b1; end
        for (int n = 0; n < 16; n++) if (hex_pat(n) == p) begin nib = n; ok = 1'b1; end
`ifdef SEG7_LOOSE_DECODE_EN
        if (p == 7'b1011000) begin nib = 7; ok = 1'b1; end
        if (p == 7'b0011000) begin nib = 9; ok = 1'b1; end
`endif
    endtask

    task automatic model_reset();
        m_prev_idx = -1; m_prev_seg = 7'h7F; m_run = 0; m_valid = 1'b0;
        for (int i = 0; i < ND; i++) begin m_nib[i] = 0; m_blk[i] = 1'b0; m_cap[i] = 1'b0; end
    endtask

    // predicts the effect of the inputs just applied at the next clock edge
    task automatic model_cycle();
        int hot, idx, nib;
        bit blk, ok, full;
        logic [4*ND-1:0] v;
        logic [ND-1:0] b;
        hot = 0; idx = 0;
        for (int i = 0; i < ND; i++) if (dig_en[i]) begin hot++; idx = i; end
        if (hot != 1) begin
            m_run = 0;
        end else begin
            if (idx == m_prev_idx && seg_n == m_prev_seg) m_run++;
            else begin m_run = 1; m_prev_idx = idx; m_prev_seg = seg_n; end
            if (m_run == SC) begin
                ref_decode(seg_n, nib, blk, ok);
                m_nib[idx] = nib; m_blk[idx] = blk; m_cap[idx] = 1'b1;
                if (!ok) err_q.push_back(cyc + 1);
            end
        end
        full = 1'b1;
        for (int i = 0; i < ND; i++) if (!m_cap[i]) full = 1'b0;
        if (full && (!m_valid || out_ready)) begin
            for (int i = 0; i < ND; i++) begin
                v[4*i +: 4] = 4'(m_nib[i]);
                b[i] = m_blk[i];
                m_cap[i] = 1'b0;
            end
            exp_q.push_back({32'(cyc + 1), v, b});
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_out(input logic v, input logic [4*ND-1:0] val, input logic [ND-1:0] b);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("value", 32'(value), 32'(val));
        chk("blank", 32'(blank), 32'(b));
    endtask

    // driver tasks
    task automatic drive(input logic [ND-1:0] de, input logic [6:0] sn, input logic rdy);
        @(posedge clk); #2;
        rst = 1'b0; dig_en = de; seg_n = sn; out_ready = rdy;
        model_cycle();
    endtask

    task automatic burst(input logic [ND-1:0] de, input logic [6:0] sn, input int n, input logic rdy);
        repeat (n) drive(de, sn, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; dig_en = '0; out_ready = 1'b0;
        model_reset();
        @(posedge clk); #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset value", 32'(value), 32'd0);
        chk("reset blank", 32'(blank), 32'd0);
        chk("reset pattern_err", 32'(pattern_err), 32'd0);
        rst = 1'b0;
        model_cycle();
    endtask

    // monitor / scoreboard
    logic            pv = 1'b0, pr = 1'b0;
    logic [4*ND-1:0] pvalue = '0;
    logic [ND-1:0]   pblank = '0;
    always @(negedge clk) begin
        logic [FW-1:0] e;
        int ec;
        if (out_valid === 1'b1 && (!pv || pr)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL frame: unexpected frame value=%h blank=%b at cycle %0d", value, blank, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({value, blank} !== e[5*ND-1:0] || cyc != int'(e[FW-1 -: 32])) begin
                    n_err++;
                    $display("FAIL frame: got value=%h blank=%b cycle=%0d, expected value=%h blank=%b cycle=%0d",
                             value, blank, cyc, e[5*ND-1:ND], e[ND-1:0], int'(e[FW-1 -: 32]));
                end
            end
        end else if (out_valid === 1'b1 && pv && !pr) begin
            n_vec++;
            if (value !== pvalue || blank !== pblank) begin
                n_err++;
                $display("FAIL hold: got value=%h blank=%b, expected held value=%h blank=%b", value, blank, pvalue, pblank);
            end
        end
        if (pattern_err === 1'b1) begin
            n_vec++;
            if (err_q.size() == 0) begin
                n_err++;
                $display("FAIL pattern_err: unexpected pulse at cycle %0d", cyc);
            end else begin
                ec = err_q.pop_front();
                if (ec != cyc) begin
                    n_err++;
                    $display("FAIL pattern_err: pulse at cycle %0d, expected cycle %0d", cyc, ec);
                end
            end
        end
        pv = out_valid; pr = out_ready; pvalue = value; pblank = blank;
    end

    // stimulus
    initial begin
        logic [ND-1:0] de;
        logic [6:0]    sn;
        int len, sel, rmode;
        model_reset();
        do_reset();

        // frame 12
        burst(2'b01, 7'b0100100, 4, 1'b1);
        burst(2'b10, 7'b1111001, 4, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
        chk_out(1'b1, 8'h12, 2'b00);
        chk("no pattern_err", 32'(pattern_err), 32'd0);

        // too short a hold, then no strobe
        burst(2'b01, 7'b0100100, 3, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
        chk("short hold out_valid", 32'(out_valid), 32'd0);

        // blank upper digit, F lower
        burst(2'b10, 7'b1111111, 4, 1'b1);
        burst(2'b01, 7'b0001110, 4, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
        chk_out(1'b1, 8'h0F, 2'b10);

        // unrecognised pattern
        burst(2'b01, 7'b0101010, 4, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
        chk("pattern_err pulse", 32'(pattern_err), 32'd1);
        drive(2'b00, 7'h7F, 1'b1);
        chk("pattern_err single", 32'(pattern_err), 32'd0);
        burst(2'b10, 7'b1000000, 4, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
        chk_out(1'b1, 8'h00, 2'b00);

        // backpressure: 34 held while 56 completes
        burst(2'b01, 7'b0011001, 4, 1'b0);
        burst(2'b10, 7'b0110000, 4, 1'b0);
        drive(2'b00, 7'h7F, 1'b0);
        chk_out(1'b1, 8'h34, 2'b00);
        burst(2'b01, 7'b0000010, 4, 1'b0);
        burst(2'b10, 7'b0010010, 4, 1'b0);
        drive(2'b00, 7'h7F, 1'b0);
        chk_out(1'b1, 8'h34, 2'b00);
        drive(2'b00, 7'h7F, 1'b1);
        drive(2'b00, 7'h7F, 1'b0);
        chk_out(1'b1, 8'h56, 2'b00);

        // reset mid-frame discards the partial capture
        burst(2'b01, 7'b1111000, 4, 1'b0);
        do_reset();
        burst(2'b10, 7'b0010000, 4, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
        chk("partial discarded", 32'(out_valid), 32'd0);
        burst(2'b01, 7'b0000000, 4, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
        chk_out(1'b1, 8'h98, 2'b00);

        // loose glyph variant
        burst(2'b01, 7'b1011000, 4, 1'b1);
        burst(2'b10, 7'b1000000, 4, 1'b1);
        drive(2'b00, 7'h7F, 1'b1);
`ifdef SEG7_LOOSE_DECODE_EN
        chk_out(1'b1, 8'h07, 2'b00);
`else
        chk_out(1'b1, 8'h00, 2'b00);
`endif

        // randomized traffic
        for (int b = 0; b < 300; b++) begin
            len   = $urandom_range(1, 6);
            sel   = $urandom_range(0, 99);
            rmode = $urandom_range(0, 3);
            de = '0;
            if (sel < 85) de[$urandom_range(0, ND-1)] = 1'b1;
            else if (sel >= 93) de = '1;
            sel = $urandom_range(0, 99);
            if (sel < 60) sn = hex_pat($urandom_range(0, 15));
            else if (sel < 75) sn = 7'h7F;
            else if (sel < 85) sn = (sel < 80) ? 7'b1011000 : 7'b0011000;
            else sn = 7'($urandom_range(0, 127));
            for (int k = 0; k < len; k++)
                drive(de, sn, (rmode == 0) ? 1'b0 : ($urandom_range(0, 2) != 0));
        end

        // drain
        repeat (12) drive(2'b00, 7'h7F, 1'b1);
        @(posedge clk); @(negedge clk); #1;
        chk("frames outstanding", 32'(exp_q.size()), 32'd0);
        chk("errors outstanding", 32'(err_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
